uart_tx_frame: RTL
==================

# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 free-running `uart_tx`. Adds a valid/ready byte handshake, configurable data width, optional odd/even parity and one or two stop bits. Sits between a byte producer (FIFO or register interface) and the board TX pin. Each frame is serialised LSB first at `F/BAUD` clocks per bit.

## Interface
- `BAUD`, 115200, line rate in bit/s.
- `F`, 50000000, `clk` frequency in Hz.
- `DATA_BITS`, 8, data bits per frame, legal range 5..9.
- `PARITY`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1, stop bits per frame, 1 or 2.
- `clk`  input  1  system clock. All logic is on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `data`  input  DATA_BITS  byte to send. Sampled only on handshake.
- `valid`  input  1  producer has a byte on `data`.
- `ready`  output  1  transmitter can accept a byte this cycle.
- `tx`  output  1  serial line, idle high.
- `busy`  output  1  a frame is in progress from the start bit through the last stop bit.

## Operation
- `CPB = F / BAUD`, integer division with truncation; 434 at the defaults. Elaboration fails if `CPB < 2`.
- `FRAME_BITS = 1 + DATA_BITS + (PARITY != 0) + STOP_BITS`.
- The state machine has five states: IDLE, START, DATA, PAR, STOP.
  - IDLE: `ready=1`, `busy=0`, `tx=1`. When `valid && ready`, latch `data` into the shift register, compute parity, clear the bit counter and go to START.
  - START: `tx=0` for CPB cycles, then go to DATA.
  - DATA: `tx` = shift register bit 0, LSB first. The register shifts right every CPB cycles. After DATA_BITS bits, go to PAR if `PARITY != 0`, otherwise go to STOP.
  - PAR: `tx` = parity bit for CPB cycles. Even parity is the XOR of the latched data bits. Odd parity is the inverse of that XOR.
  - STOP: `tx=1` for `STOP_BITS*CPB` cycles, then go to IDLE.
- Only a clock-divider counter (0..CPB-1) and a bit counter sized for 9 bits are permitted. No fractional baud.
- Changes on `data` or `valid` outside the IDLE handshake are ignored. The latched byte is held for the whole frame.
- `valid` held high continuously produces back-to-back frames separated by exactly one IDLE cycle of `tx=1`.

## Timing
- Reset values, one cycle after `rst` is sampled high:
  - `tx=1`, `ready=0`, `busy=0`.
  - State is IDLE, and both counters and the shift register are 0.
  - `ready` rises in the first cycle after `rst` deasserts.
- Reset mid-frame aborts the frame. `tx` is 1 on the next edge and the byte is discarded. Reset has priority over every other input.
- Every output is driven from a register. `ready` is decoded from the registered state, so it carries no combinational path from `valid`.
- Handshake at edge k means `valid && ready` is sampled at k:
  - The start bit (`tx=0`) appears at k+1 and lasts CPB cycles.
  - `ready` falls at k+1 and `busy` rises at k+1.
- Data bit i occupies cycles `k+1+(1+i)*CPB` through `k+(2+i)*CPB`.
- The last stop cycle is `k + FRAME_BITS*CPB`.
  - At `k + FRAME_BITS*CPB + 1`: `busy=0`, `ready=1`, `tx=1`.
  - The earliest next handshake is at that edge.
  - The minimum frame period is therefore `FRAME_BITS*CPB + 1` cycles.
- `valid` low in IDLE keeps `tx=1` indefinitely, with no spurious start bit.

## Test plan
- 8N1 at defaults (CPB=434), send 0xD3:
  - Sampling mid-bit gives `tx` = 0,1,1,0,0,1,0,1,1,1.
  - `busy` is high for exactly 4340 cycles.
  - `ready` returns at handshake+4341.
- 8E1, send 0xD3 (popcount 5):
  - The parity bit is 1 and the frame is 11 bits.
  - With `PARITY=1` the same byte gives parity bit 0.
- 7N2, `DATA_BITS=7`, `STOP_BITS=2`, send 0x2C:
  - `tx` bits are 0, 0,0,1,1,0,1,0, 1,1.
  - Line high time at the end of the frame is `2*CPB`.
- Back-to-back: hold `valid=1` with 0x2C, then 0xFF:
  - The second start bit falls exactly `10*CPB+1` cycles after the first.
  - `data` changed mid-frame does not alter the bits in flight.
- Reset mid-frame:
  - Assert `rst` during data bit 3 for 10 cycles. `tx=1` from the next edge onward.
  - After release, `ready=1` and a new byte 0x9B is sent correctly.
- Idle stability: `valid=0` for `20*CPB` cycles after reset. `tx` stays 1 throughout and `busy` stays 0.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with a valid/ready byte handshake.
// Serialises start bit, DATA_BITS data bits (LSB first), optional parity bit and
// one or two stop bits. Every bit lasts CPB = F/BAUD clock cycles.
//
// Ports:
//   clk    system clock, rising edge
//   rst    synchronous active-high reset, aborts any frame in progress
//   data   byte to send, sampled only on the valid && ready handshake
//   valid  producer has a byte on data
//   ready  transmitter accepts a byte this cycle (registered)
//   tx     serial line, idle high (registered)
//   busy   frame in progress, start bit through last stop bit (registered)
module uart_tx_frame #(
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned F         = 50000000,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned CPB   = F / BAUD;
    localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
    localparam int unsigned BIT_W = 4;

    // Reject configurations the datapath cannot serve.
    if (CPB < 2) begin : g_chk_cpb
        $error("uart_tx_frame: F/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (PARITY > 2) begin : g_chk_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_clk_cnt;
    logic [BIT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_tx;
    logic                 r_ready;
    logic                 r_busy;

    logic                 w_bit_end;
    logic                 w_handshake;
    logic                 w_par_calc;

    // Last cycle of the current bit period.
    assign w_bit_end   = (r_clk_cnt == CNT_W'(CPB - 1));
    assign w_handshake = valid && r_ready;
    // Even parity is the XOR of the data bits; odd parity is its inverse.
    assign w_par_calc  = (PARITY == 1) ? ~(^data) : (^data);

    // Frame sequencer; tx is updated on the same edge as each state change so
    // every bit boundary lines up exactly with the divider wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_handshake) begin
                        r_shift   <= data;
                        r_par     <= w_par_calc;
                        r_bit_cnt <= '0;
                        r_clk_cnt <= '0;
                        r_tx      <= 1'b0;
                        r_ready   <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_START;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            if (PARITY != 0) begin
                                r_tx    <= r_par;
                                r_state <= S_PAR;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= S_STOP;
                            end
                        end else begin
                            // Next bit is already at position 1 of the register.
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end

                S_PAR: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_cnt <= '0;
                        r_tx      <= 1'b1;
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                            r_bit_cnt <= '0;
                            r_tx      <= 1'b1;
                            r_ready   <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_state   <= S_IDLE;
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                    r_tx      <= 1'b1;
                    r_ready   <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign ready = r_ready;
    assign tx    = r_tx;
    assign busy  = r_busy;

endmodule
